axis_adc_stream_arbiter: RTL
============================

// Module: axis_adc_stream_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single 128-bit PL->PS capture stream among NUM_CH adc_ctrl channel streams.
//  Grants one channel at a time for a fixed burst of BURST_LEN beats, tags beats with channel index, marks burst end.
//  Sits between the per-channel adc_ctrl output FIFOs and the PL->PS width converter; one clock domain.
// PARAMETERS
//  NUM_CH     4    number of requesting channels (2..16)
//  DATA_W     128  beat width, all ports
//  BURST_LEN  16   beats per grant (>=1)
// PORTS
//  clk            in   1             system clock
//  rst            in   1             asynchronous reset, active-high
//  s_axis_tdata   in   NUM_CH*DATA_W channel i at [i*DATA_W +: DATA_W]
//  s_axis_tvalid  in   NUM_CH        per-channel valid
//  s_axis_tready  out  NUM_CH        per-channel ready
//  m_axis_tdata   out  DATA_W        muxed beat to PL->PS converter
//  m_axis_tvalid  out  1             beat valid
//  m_axis_tready  in   1             downstream ready
//  m_axis_tlast   out  1             high on final beat of burst
//  m_axis_tuser   out  8             granted channel index, zero-extended
//  ch_enable      in   NUM_CH        per-channel arbitration mask
//  flush          in   1             synchronous abort (gpio_ctrl adc_buffer_flush)
//  busy           out  1             high in ARB or XFER
//  burst_count    out  32            completed bursts since reset/flush, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: state IDLE, beat_cnt 0, grant 0, rr pointer = NUM_CH-1 (ch0 wins first); all outputs 0, burst_count 0.
//  States: IDLE -> ARB -> XFER -> IDLE.
//   IDLE: req = s_axis_tvalid & ch_enable; any req -> ARB next cycle.
//   ARB: pick first req channel after rr pointer (ptr+1 .. ptr+NUM_CH mod NUM_CH); register grant; -> XFER.
//        if req now zero, -> IDLE with no grant. Request-to-first-beat latency: 2 cycles.
//   XFER: combinational path: m_axis_tdata = s_tdata[grant]; m_axis_tvalid = s_tvalid[grant];
//        s_axis_tready[grant] = m_axis_tready; all other s_axis_tready = 0; m_axis_tuser = grant.
//        beat = m_tvalid & m_tready; beat increments beat_cnt.
//        m_axis_tlast = (beat_cnt == BURST_LEN-1). Beat with tlast: rr pointer <= grant, beat_cnt <= 0,
//        burst_count +1, -> IDLE.
//  Outside XFER: m_axis_tvalid, m_axis_tlast, all s_axis_tready = 0; m_axis_tdata/tuser hold 0.
//  No preemption: burst stays granted while grant channel tvalid low or ch_enable drops; waits for beats.
//  Backpressure: m_tready low -> no beat, beat_cnt holds, source sees tready low.
//  flush (any state, priority over all): next cycle IDLE, beat_cnt 0, rr pointer NUM_CH-1, burst_count 0;
//   no beat accepted in flush cycle (s_axis_tready forced 0 while flush high).
//  Reset mid-burst: outputs drop to 0 asynchronously; partial burst discarded, no tlast issued.
//  busy = (state != IDLE).
// TESTING
//  BURST_LEN=4, ch2 only valid, tready=1 -> 4 beats tuser=2, tlast on beat 4, IDLE+ARB gap, repeats.
//  all 4 valid continuously -> grant order 0,1,2,3,0; burst_count=5 after 20 beats.
//  m_tready low 3 cycles at beat 2 -> tdata stable, beat_cnt holds 1, tlast still on 4th accepted beat.
//  flush at beat 2 of ch1 burst -> next cycle IDLE, tvalid 0, burst_count 0, next grant ch0.
//  ch_enable=4'b1101, all valid -> order 0,2,3,0; ch1 s_axis_tready never high.
//  rst asserted mid-XFER (no clock edge) -> m_axis_tvalid and s_axis_tready go 0 immediately.

Source files
------------

// File: rtl/axis_adc_stream_arbiter.sv
// ---------------------------------------------------------------------------
// axis_adc_stream_arbiter
//   Round-robin arbiter that shares one DATA_W-bit AXI-Stream capture path
//   (to the PL->PS width converter) among NUM_CH adc_ctrl channel streams.
//   A grant covers a fixed burst of BURST_LEN beats. Every beat carries the
//   granted channel index in tuser, and tlast marks the final beat of the
//   burst.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   s_axis_*        NUM_CH channel streams; channel i data at
//                   [i*DATA_W +: DATA_W]
//   m_axis_*        muxed output stream; tuser is the granted channel index
//   ch_enable       per-channel arbitration mask
//   flush           synchronous abort: return to IDLE and clear the counters
//   busy            high while arbitrating or transferring
//   burst_count     bursts completed since reset or flush (wraps)
// ---------------------------------------------------------------------------

// Per-channel request qualification and ready steering.
module axis_adc_arb_lane #(
    parameter int IDX = 0,
    parameter int GW  = 2
) (
    input  logic          tvalid,
    input  logic          enable,
    input  logic          xfer_open,
    input  logic          m_ready,
    input  logic [GW-1:0] grant,
    output logic          req,
    output logic          tready
);
    assign req    = tvalid & enable;
    assign tready = xfer_open & m_ready & (grant == GW'(IDX));
endmodule

module axis_adc_stream_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [7:0]               m_axis_tuser,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     flush,
    output logic                     busy,
    output logic [31:0]              burst_count
);
    localparam int GW = $clog2(NUM_CH);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   rr_ptr;
    logic [CW-1:0]   beat_cnt;
    logic [NUM_CH-1:0] req;
    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic            xfer, xfer_open, beat, last_beat;
    logic            pick_found;
    logic [GW-1:0]   pick_idx;

    assign xfer      = (state == XFER);
    // flush closes the transfer window in the same cycle so no beat slips through
    assign xfer_open = xfer & ~flush;
    assign last_beat = (beat_cnt == CW'(BURST_LEN - 1));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign ch_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];

        axis_adc_arb_lane #(
            .IDX (i),
            .GW  (GW)
        ) u_lane (
            .tvalid    (s_axis_tvalid[i]),
            .enable    (ch_enable[i]),
            .xfer_open (xfer_open),
            .m_ready   (m_axis_tready),
            .grant     (grant),
            .req       (req[i]),
            .tready    (s_axis_tready[i])
        );
    end

    assign m_axis_tvalid = xfer_open & s_axis_tvalid[grant];
    assign m_axis_tdata  = xfer ? ch_data[grant] : '0;
    assign m_axis_tuser  = xfer ? {{(8-GW){1'b0}}, grant} : 8'd0;
    assign m_axis_tlast  = xfer & last_beat;
    assign beat          = m_axis_tvalid & m_axis_tready;
    assign busy          = (state != IDLE);

    // Round-robin pick: first requester after rr_ptr. Scanning from the far
    // end toward ptr+1 lets the nearest requester overwrite the result.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ARB;
            ARB:     state_nxt = pick_found ? XFER : IDLE;
            XFER:    if (beat && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= GW'(NUM_CH - 1);
            beat_cnt    <= '0;
            burst_count <= '0;
        end else if (flush) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= GW'(NUM_CH - 1);
            beat_cnt    <= '0;
            burst_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && pick_found)
                grant <= pick_idx;
            if (beat) begin
                if (last_beat) begin
                    beat_cnt    <= '0;
                    rr_ptr      <= grant;
                    burst_count <= burst_count + 32'd1;
                end else begin
                    beat_cnt <= beat_cnt + CW'(1);
                end
            end
        end
    end
endmodule
